// File: rtl/toggle_bank.sv
// toggle_bank: per-channel synchronise, debounce and edge detect, mapped by a global mode to toggle/follow/hold
module toggle_bank #(
  parameter int CHANNELS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] Signal_Pulse,
  input  logic [1:0]          mode_i,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [CHANNELS-1:0] load_value_i,
  output logic [CHANNELS-1:0] Toggle_Signal,
  output logic [CHANNELS-1:0] change_o,
  output logic                any_change_o
);
  localparam int CW = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  logic [CHANNELS-1:0] s, stable, ev, rise, nxt;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sq;
    logic st;
    always_ff @(posedge clk or negedge reset)
      if (!reset) sq <= '0;
      else sq <= {sq[SYNC_STAGES-2:0], Signal_Pulse[i]};
    assign s[i] = sq[SYNC_STAGES-1];
    assign stable[i] = st;
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign ev[i] = s[i] != st;
      always_ff @(posedge clk or negedge reset)
        if (!reset) st <= 1'b0;
        else st <= s[i];
    end else begin : g_deb
      logic [CW-1:0] cnt;
      // the level must differ from stable for D consecutive samples; any bounce restarts
      assign ev[i] = (s[i] != st) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          cnt <= '0;
          st <= 1'b0;
        end else if (s[i] == st) cnt <= '0;
        else if (ev[i]) begin
          st <= s[i];
          cnt <= '0;
        end else cnt <= cnt + CW'(1);
    end
    assign rise[i] = ev[i] & s[i];
  end
  always_comb
    nxt = clear_i ? RESET_VALUE :
          load_i ? load_value_i :
          (mode_i == 2'b00) ? Toggle_Signal ^ rise :
          (mode_i == 2'b01) ? Toggle_Signal ^ ev :
          (mode_i == 2'b10) ? stable : Toggle_Signal;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      Toggle_Signal <= RESET_VALUE;
      change_o <= '0;
      any_change_o <= 1'b0;
    end else begin
      Toggle_Signal <= nxt;
      change_o <= nxt ^ Toggle_Signal;
      any_change_o <= |(nxt ^ Toggle_Signal);
    end
endmodule

// File: tb/tb_toggle_bank.sv
// tb_toggle_bank: directed vectors for toggle_bank (4-channel debounced instance and 1-channel bypass instance)
module tb_toggle_bank;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] pulse, ldv, tog, chg;
  logic [1:0] mode;
  logic clr, ld, any;
  logic pulse_b, tog_b, chg_b, any_b;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  toggle_bank #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_VALUE(4'b0101)) dut (
    .clk(clk), .reset(reset), .Signal_Pulse(pulse), .mode_i(mode), .clear_i(clr), .load_i(ld),
    .load_value_i(ldv), .Toggle_Signal(tog), .change_o(chg), .any_change_o(any));
  toggle_bank #(.CHANNELS(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .RESET_VALUE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .Signal_Pulse(pulse_b), .mode_i(2'b00), .clear_i(1'b0), .load_i(1'b0),
    .load_value_i(1'b0), .Toggle_Signal(tog_b), .change_o(chg_b), .any_change_o(any_b));
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b0; pulse = '0; mode = 2'b00; clr = 1'b0; ld = 1'b0; ldv = '0; pulse_b = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      pulse = ~pulse;
      tick(1);
      chk("rst_tog", tog, 4'b0101);
      chk("rst_chg", chg, 4'b0000);
      chk("rst_any", 4'(any), 4'd0);
    end
    pulse = '0;
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("idle_tog", tog, 4'b0101);
      chk("idle_chg", chg, 4'b0000);
    end
    pulse[0] = 1'b1;
    tick(17);
    chk("lat_before", tog, 4'b0101);
    tick(1);
    chk("lat_flip", tog, 4'b0100);
    chk("lat_chg", chg, 4'b0001);
    chk("lat_any", 4'(any), 4'd1);
    tick(1);
    chk("lat_chg_1cyc", chg, 4'b0000);
    pulse[0] = 1'b0;
    tick(25);
    chk("fall_ignored", tog, 4'b0100);
    chk("fall_chg", chg, 4'b0000);
    pulse[0] = 1'b1;
    tick(18);
    chk("press2_flip", tog, 4'b0101);
    chk("press2_chg", chg, 4'b0001);
    pulse[0] = 1'b0;
    tick(25);
    chk("press2_rel", tog, 4'b0101);
    pulse[1] = 1'b1;
    tick(10);
    pulse[1] = 1'b0;
    tick(3);
    chk("bounce_mid", tog, 4'b0101);
    pulse[1] = 1'b1;
    tick(17);
    chk("bounce_before", tog, 4'b0101);
    tick(1);
    chk("bounce_flip", tog, 4'b0111);
    chk("bounce_chg", chg, 4'b0010);
    pulse[1] = 1'b0;
    tick(25);
    pulse[3] = 1'b1;
    tick(15);
    pulse[3] = 1'b0;
    tick(25);
    chk("short_pulse", tog, 4'b0111);
    mode = 2'b01;
    pulse[2] = 1'b1;
    tick(18);
    chk("any_edge_rise", tog, 4'b0011);
    pulse[2] = 1'b0;
    tick(18);
    chk("any_edge_fall", tog, 4'b0111);
    chk("any_edge_chg", chg, 4'b0100);
    mode = 2'b10;
    tick(1);
    chk("follow_snap", tog, 4'b0000);
    chk("follow_snap_chg", chg, 4'b0111);
    pulse[2] = 1'b1;
    tick(25);
    chk("follow_high", tog, 4'b0100);
    pulse[2] = 1'b0;
    tick(25);
    chk("follow_low", tog, 4'b0000);
    mode = 2'b11;
    pulse[0] = 1'b1;
    tick(25);
    chk("hold_tog", tog, 4'b0000);
    chk("hold_chg", chg, 4'b0000);
    mode = 2'b00;
    tick(5);
    chk("hold_dropped", tog, 4'b0000);
    pulse[0] = 1'b0;
    tick(25);
    chk("hold_rel", tog, 4'b0000);
    ld = 1'b1; ldv = 4'b1010;
    tick(1);
    chk("load_tog", tog, 4'b1010);
    chk("load_chg", chg, 4'b1010);
    ld = 1'b0;
    pulse[3] = 1'b1;
    tick(17);
    clr = 1'b1; ld = 1'b1; ldv = 4'b1111;
    tick(1);
    chk("prio_clear", tog, 4'b0101);
    chk("prio_chg", chg, 4'b1111);
    clr = 1'b0;
    tick(1);
    chk("prio_load", tog, 4'b1111);
    chk("prio_load_chg", chg, 4'b1010);
    ld = 1'b0;
    tick(1);
    chk("quiet_chg", chg, 4'b0000);
    chk("quiet_any", 4'(any), 4'd0);
    clr = 1'b1;
    tick(1);
    chk("clear_tog", tog, 4'b0101);
    chk("clear_chg", chg, 4'b1010);
    tick(1);
    chk("clear_again_chg", chg, 4'b0000);
    chk("clear_again_any", 4'(any), 4'd0);
    clr = 1'b0;
    pulse[3] = 1'b0;
    tick(25);
    chk("prio_rel", tog, 4'b0101);
    pulse_b = 1'b1;
    tick(2);
    chk("byp_before", 4'(tog_b), 4'd0);
    tick(1);
    chk("byp_flip", 4'(tog_b), 4'd1);
    chk("byp_chg", 4'(chg_b), 4'd1);
    chk("byp_any", 4'(any_b), 4'd1);
    tick(1);
    chk("byp_chg_1cyc", 4'(chg_b), 4'd0);
    pulse_b = 1'b0;
    tick(4);
    chk("byp_fall", 4'(tog_b), 4'd1);
    pulse[1] = 1'b1;
    tick(10);
    reset = 1'b0;
    #1;
    chk("midrst_tog", tog, 4'b0101);
    chk("midrst_b", 4'(tog_b), 4'd0);
    tick(2);
    chk("midrst_chg", chg, 4'b0000);
    reset = 1'b1;
    tick(17);
    chk("midrst_restart", tog, 4'b0101);
    tick(1);
    chk("midrst_flip", tog, 4'b0111);
    chk("midrst_chg2", chg, 4'b0010);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
